id_operand_unit: RTL and testbench
==================================

# id_operand_unit

Decode-stage operand unit for the 5-stage MIPS pipeline. It combines three functions: immediate extension (EXT), MEM/WB result bypassing onto register-file read data (FORWARD), and branch-condition evaluation on the bypassed operands (BRANCH). All three results are available combinationally for same-cycle next-PC selection. They are also captured in an output register that feeds the ID/EX boundary.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears the output register on the next edge, like rst.
- imm16  in  16  instruction immediate field, instr[15:0].
- extop  in  1  0 = low-half extend, 1 = load-upper (imm16 << 16).
- exsign  in  1  with extop=0: 1 = sign-extend, 0 = zero-extend.
- rs, rt  in  5 each  source register numbers.
- rd1, rd2  in  32 each  raw GPR read data for rs and rt.
- MEM_BACK  in  38  {regWrite[37], Wd[36:5], rw[4:0]} from the MEM stage.
- WB_BACK  in  38  same layout, from the WB stage.
- USE_MEM_BACK, USE_WB_BACK  in  1 each  enable each bypass source.
- branchType  in  3  branch condition code.
- f_rd1, f_rd2  out  32 each  forwarded operands (combinational).
- EXTB  out  32  extended immediate (combinational).
- branchAvail  out  1  branch condition true (combinational).
- q_rd1, q_rd2, q_ext  out  32 each  registered f_rd1, f_rd2, EXTB.
- q_branch  out  1  registered branchAvail.

## Operation
- EXT:
  - extop=1 → EXTB = {imm16, 16'h0}; exsign is ignored.
  - extop=0, exsign=1 → EXTB = {{16{imm16[15]}}, imm16}.
  - extop=0, exsign=0 → EXTB = {16'h0, imm16}.
- FORWARD, per operand (rs→f_rd1, rt→f_rd2):
  - MEM hit: USE_MEM_BACK & MEM_BACK[37] & MEM_BACK[4:0]==src & src!=0.
  - WB hit: the same test on WB_BACK with USE_WB_BACK.
  - Priority: MEM hit → MEM Wd; else WB hit → WB Wd; else raw rd.
  - When both hit, MEM wins because it is the younger result.
  - src=0 never forwards; f_rd = rd, which the GPR holds at 0.
- BRANCH, evaluated on f_rd1 (A) and f_rd2 (B), comparisons signed 32-bit:
  - 0 → none, branchAvail=0.
  - 1 → BEQ, A==B.
  - 2 → BNE, A!=B.
  - 3 → BGEZ, A>=0.
  - 4 → BGTZ, A>0.
  - 5 → BLEZ, A<=0.
  - 6 → BLTZ, A<0.
  - 7 → reserved, branchAvail=0.
- Output register, on each rising edge:
  - rst=1 or flush=1 → all q_* = 0; rst and flush are equivalent.
  - Otherwise q_rd1←f_rd1, q_rd2←f_rd2, q_ext←EXTB, q_branch←branchAvail.

## Timing
- f_rd1, f_rd2, EXTB, branchAvail: purely combinational, zero latency, no dependence on clk.
- q_* outputs: 1-cycle latency from their inputs.
- Reset value of every q_* output is 0, taking effect at the first rising edge with rst high. Before that edge the values are X.
- rst asserted mid-stream clears the register at the next edge; the combinational outputs keep following their inputs.
- No handshake; a valid input is assumed every cycle.
- Both bypass buses targeting the same register in the same cycle is legal; MEM priority resolves it.

## Test plan
- EXT:
  - imm16=16'h8001, extop=0, exsign=1 → EXTB=32'hFFFF8001.
  - Same with exsign=0 → 32'h00008001.
  - extop=1 → 32'h80010000.
- Forward priority:
  - rs=5, rd1=1, MEM_BACK={1,32'hAAAA,5}, WB_BACK={1,32'hBBBB,5} → f_rd1=32'hAAAA.
  - MEM regWrite=0 → f_rd1=32'hBBBB.
  - Both buses disabled by USE_* = 0 → f_rd1=1.
- Register 0:
  - rt=0, rd2=0, MEM_BACK={1,32'h1234,0} → f_rd2=0.
- Branch:
  - rd1=rd2=7, branchType=1 → branchAvail=1; branchType=2 → 0.
  - rd1=32'hFFFFFFFF: type 6 → 1, type 3 → 0, type 5 → 1, type 4 → 0, type 7 → 0.
- Branch on forwarded operand:
  - rd1=0, rs=3, WB_BACK={1,32'd9,3}, branchType=4 → branchAvail=1.
- Register, reset and flush:
  - Drive non-zero values and clock → q_* match the previous cycle's combinational outputs.
  - Assert rst for one edge → all q_* = 0.
  - Deassert rst, assert flush → q_* = 0; drop flush → capture resumes next edge.

Source files
------------

// File: rtl/id_operand_unit.sv
// id_operand_unit: decode-stage operand unit for a 5-stage MIPS pipeline.
// Purpose: immediate extension, MEM/WB bypass onto register-file read data,
// branch-condition evaluation on the bypassed operands, plus an output
// register that feeds the ID/EX boundary.
// Ports:
//   clk, rst, flush       clock, sync active-high reset, sync register clear
//   imm16, extop, exsign  immediate field and extension control
//   rs, rt, rd1, rd2      source register numbers and raw GPR read data
//   MEM_BACK, WB_BACK     bypass buses {regWrite, Wd[31:0], rw[4:0]}
//   USE_MEM_BACK/WB_BACK  per-source bypass enables
//   branchType            branch condition code
//   f_rd1, f_rd2, EXTB, branchAvail  combinational results
//   q_rd1, q_rd2, q_ext, q_branch    registered results (1-cycle latency)
module id_operand_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] imm16,
  input  logic        extop,
  input  logic        exsign,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [37:0] MEM_BACK,
  input  logic [37:0] WB_BACK,
  input  logic        USE_MEM_BACK,
  input  logic        USE_WB_BACK,
  input  logic [2:0]  branchType,
  output logic [31:0] f_rd1,
  output logic [31:0] f_rd2,
  output logic [31:0] EXTB,
  output logic        branchAvail,
  output logic [31:0] q_rd1,
  output logic [31:0] q_rd2,
  output logic [31:0] q_ext,
  output logic        q_branch
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] wd;
    logic [RW-1:0] rw;
  } back_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_GEZ  = 3'd3,
    BR_GTZ  = 3'd4,
    BR_LEZ  = 3'd5,
    BR_LTZ  = 3'd6,
    BR_RSVD = 3'd7
  } br_t;

  back_t w_mem;
  back_t w_wb;
  logic  w_a_zero;
  logic  w_a_neg;

  assign w_mem = back_t'(MEM_BACK);
  assign w_wb  = back_t'(WB_BACK);

  // Bypass select: MEM is the younger result and wins over WB; r0 never forwards.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] src,
    input logic [DW-1:0] raw,
    input back_t         mem,
    input back_t         wb,
    input logic          use_mem,
    input logic          use_wb
  );
    logic hit_mem;
    logic hit_wb;
    hit_mem = use_mem && mem.we && (mem.rw == src) && (src != RW'(0));
    hit_wb  = use_wb  && wb.we  && (wb.rw  == src) && (src != RW'(0));
    if (hit_mem)     fwd = mem.wd;
    else if (hit_wb) fwd = wb.wd;
    else             fwd = raw;
  endfunction

  always_comb begin
    f_rd1 = fwd(rs, rd1, w_mem, w_wb, USE_MEM_BACK, USE_WB_BACK);
    f_rd2 = fwd(rt, rd2, w_mem, w_wb, USE_MEM_BACK, USE_WB_BACK);
  end

  // Immediate extension.
  always_comb begin
    EXTB = {16'h0, imm16};
    if (extop)       EXTB = {imm16, 16'h0};
    else if (exsign) EXTB = {{16{imm16[15]}}, imm16};
  end

  // Signed compares against zero reduce to sign bit and zero test.
  assign w_a_zero = (f_rd1 == DW'(0));
  assign w_a_neg  = f_rd1[DW-1];

  always_comb begin
    branchAvail = 1'b0;
    case (br_t'(branchType))
      BR_EQ:   branchAvail = (f_rd1 == f_rd2);
      BR_NE:   branchAvail = (f_rd1 != f_rd2);
      BR_GEZ:  branchAvail = !w_a_neg;
      BR_GTZ:  branchAvail = !w_a_neg && !w_a_zero;
      BR_LEZ:  branchAvail = w_a_neg || w_a_zero;
      BR_LTZ:  branchAvail = w_a_neg;
      default: branchAvail = 1'b0;
    endcase
  end

  // ID/EX output register; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_rd1    <= '0;
      q_rd2    <= '0;
      q_ext    <= '0;
      q_branch <= 1'b0;
    end else begin
      q_rd1    <= f_rd1;
      q_rd2    <= f_rd2;
      q_ext    <= EXTB;
      q_branch <= branchAvail;
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// tb_id_operand_unit: table-driven check of id_operand_unit combinational
// outputs, followed by hand-written register / reset / flush sequences.
module tb_id_operand_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] imm16;
  logic        extop;
  logic        exsign;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [37:0] MEM_BACK;
  logic [37:0] WB_BACK;
  logic        USE_MEM_BACK;
  logic        USE_WB_BACK;
  logic [2:0]  branchType;
  logic [31:0] f_rd1;
  logic [31:0] f_rd2;
  logic [31:0] EXTB;
  logic        branchAvail;
  logic [31:0] q_rd1;
  logic [31:0] q_rd2;
  logic [31:0] q_ext;
  logic        q_branch;

  int n_cmp;
  int n_fail;

  id_operand_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .imm16(imm16), .extop(extop), .exsign(exsign),
    .rs(rs), .rt(rt), .rd1(rd1), .rd2(rd2),
    .MEM_BACK(MEM_BACK), .WB_BACK(WB_BACK),
    .USE_MEM_BACK(USE_MEM_BACK), .USE_WB_BACK(USE_WB_BACK),
    .branchType(branchType),
    .f_rd1(f_rd1), .f_rd2(f_rd2), .EXTB(EXTB), .branchAvail(branchAvail),
    .q_rd1(q_rd1), .q_rd2(q_rd2), .q_ext(q_ext), .q_branch(q_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm16;
    logic        extop;
    logic        exsign;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [37:0] mem;
    logic [37:0] wb;
    logic        use_mem;
    logic        use_wb;
    logic [2:0]  bt;
    logic [31:0] e_f1;
    logic [31:0] e_f2;
    logic [31:0] e_ext;
    logic        e_br;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imm16 = v.imm16; extop = v.extop; exsign = v.exsign;
    rs = v.rs; rt = v.rt; rd1 = v.rd1; rd2 = v.rd2;
    MEM_BACK = v.mem; WB_BACK = v.wb;
    USE_MEM_BACK = v.use_mem; USE_WB_BACK = v.use_wb;
    branchType = v.bt;
  endtask

  task automatic chk_q(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] ee, input logic eb);
    chk({tag, ".q_rd1"}, q_rd1, e1);
    chk({tag, ".q_rd2"}, q_rd2, e2);
    chk({tag, ".q_ext"}, q_ext, ee);
    chk({tag, ".q_branch"}, 32'(q_branch), 32'(eb));
  endtask

  initial begin
    vec_t s;
    n_cmp = 0;
    n_fail = 0;

    // imm, extop, exsign, rs, rt, rd1, rd2, mem, wb, use_mem, use_wb, bt, f1, f2, ext, br
    vecs[0]  = '{16'h8001, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0, 3'd0,
                 32'd0, 32'd0, 32'hFFFF8001, 1'b0};
    vecs[1]  = '{16'h8001, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0, 3'd0,
                 32'd0, 32'd0, 32'h00008001, 1'b0};
    vecs[2]  = '{16'h8001, 1'b1, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0, 3'd0,
                 32'd0, 32'd0, 32'h80010000, 1'b0};
    vecs[3]  = '{16'h7FFF, 1'b0, 1'b1, 5'd5, 5'd6, 32'd1, 32'd2, {1'b1, 32'hAAAA, 5'd5},
                 {1'b1, 32'hBBBB, 5'd5}, 1'b1, 1'b1, 3'd0, 32'hAAAA, 32'd2, 32'h00007FFF, 1'b0};
    vecs[4]  = '{16'h0000, 1'b0, 1'b0, 5'd5, 5'd6, 32'd1, 32'd2, {1'b0, 32'hAAAA, 5'd5},
                 {1'b1, 32'hBBBB, 5'd5}, 1'b1, 1'b1, 3'd0, 32'hBBBB, 32'd2, 32'd0, 1'b0};
    vecs[5]  = '{16'h0000, 1'b0, 1'b0, 5'd5, 5'd6, 32'd1, 32'd2, {1'b1, 32'hAAAA, 5'd5},
                 {1'b1, 32'hBBBB, 5'd5}, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0};
    vecs[6]  = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd0, 32'd5, 32'd0, {1'b1, 32'h1234, 5'd0},
                 38'd0, 1'b1, 1'b1, 3'd2, 32'd5, 32'd0, 32'd0, 1'b1};
    vecs[7]  = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'd7, 32'd7, 38'd0, 38'd0, 1'b1, 1'b1, 3'd1,
                 32'd7, 32'd7, 32'd0, 1'b1};
    vecs[8]  = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'd7, 32'd7, 38'd0, 38'd0, 1'b1, 1'b1, 3'd2,
                 32'd7, 32'd7, 32'd0, 1'b0};
    vecs[9]  = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0,
                 3'd6, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0,
                 3'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0};
    vecs[11] = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0,
                 3'd5, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0,
                 3'd4, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0};
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 38'd0, 38'd0, 1'b0,
                 1'b0, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[14] = '{16'h0000, 1'b0, 1'b0, 5'd3, 5'd2, 32'd0, 32'd4, 38'd0, {1'b1, 32'd9, 5'd3},
                 1'b1, 1'b1, 3'd4, 32'd9, 32'd4, 32'd0, 1'b1};
    vecs[15] = '{16'hFFFF, 1'b0, 1'b1, 5'd4, 5'd4, 32'd1, 32'd2, {1'b1, 32'd11, 5'd4},
                 {1'b1, 32'd22, 5'd4}, 1'b1, 1'b1, 3'd1, 32'd11, 32'd11, 32'hFFFFFFFF, 1'b1};
    vecs[16] = '{16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 38'd0, 38'd0, 1'b0, 1'b0, 3'd5,
                 32'd0, 32'd0, 32'd0, 1'b1};

    rst = 1'b1;
    flush = 1'b0;
    drive(vecs[0]);
    @(posedge clk); #1;
    chk_q("reset", 32'd0, 32'd0, 32'd0, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d.f_rd1", i), f_rd1, vecs[i].e_f1);
      chk($sformatf("v%0d.f_rd2", i), f_rd2, vecs[i].e_f2);
      chk($sformatf("v%0d.EXTB", i), EXTB, vecs[i].e_ext);
      chk($sformatf("v%0d.branchAvail", i), 32'(branchAvail), 32'(vecs[i].e_br));
    end

    // Capture: forwarded operand and branch outcome land in q_* one edge later.
    s = '{16'h1234, 1'b0, 1'b1, 5'd3, 5'd7, 32'd0, 32'hCAFE0001, 38'd0, {1'b1, 32'd9, 5'd3},
          1'b0, 1'b1, 3'd4, 32'd9, 32'hCAFE0001, 32'h00001234, 1'b1};
    @(negedge clk);
    drive(s);
    @(posedge clk); #1;
    chk_q("capture", s.e_f1, s.e_f2, s.e_ext, s.e_br);

    // Mid-stream reset clears q_* while combinational outputs keep following inputs.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_q("midrst", 32'd0, 32'd0, 32'd0, 1'b0);
    chk("midrst.f_rd1", f_rd1, 32'd9);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_q("recap", s.e_f1, s.e_f2, s.e_ext, s.e_br);

    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk_q("flush", 32'd0, 32'd0, 32'd0, 1'b0);

    // Drop flush with new inputs; capture resumes on the next edge.
    @(negedge clk);
    flush = 1'b0;
    extop = 1'b1;
    branchType = 3'd0;
    @(posedge clk); #1;
    chk_q("resume", 32'd9, 32'hCAFE0001, 32'h12340000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
